// File: rtl/uart_fifo_regs_if.sv
// Avalon-MM control bus between the system interconnect and the UART register block.
// Latency: none (signal bundle only).
// Backpressure: waitrequest from the slave stalls the master.
interface uart_fifo_regs_if;
    logic [7:0]  address;
    logic        read;
    logic [31:0] readdata;
    logic [1:0]  response;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, response, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, response, waitrequest
    );
endinterface

// File: rtl/uart_fifo_regs.sv
// UART register front-end: Avalon-MM CSRs, TX/RX character FIFOs, sticky error flags, maskable IRQ.
// Latency: writes zero wait states; reads one wait state with registered data; FIFO pushes visible next cycle.
// Backpressure: tx_tvalid while TX FIFO holds data; rx_tready low when RX FIFO full; bus push into full TX is dropped and flagged.
module uart_fifo_regs #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned TX_DEPTH     = 16,
    parameter int unsigned RX_DEPTH     = 16,
    parameter logic [15:0] PRESCALE_RST = 16'd54
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_fifo_regs_if.slave       ctrl,
    output logic [DATA_WIDTH-1:0] tx_tdata,
    output logic                  tx_tvalid,
    input  logic                  tx_tready,
    input  logic [DATA_WIDTH-1:0] rx_tdata,
    input  logic                  rx_tvalid,
    output logic                  rx_tready,
    input  logic                  tx_busy,
    input  logic                  rx_busy,
    input  logic                  rx_overrun_error,
    input  logic                  rx_frame_error,
    output logic [15:0]           prescale,
    output logic                  irq
);
    localparam int unsigned TXA = $clog2(TX_DEPTH);
    localparam int unsigned RXA = $clog2(RX_DEPTH);
    localparam int unsigned TXL = TXA + 1;
    localparam int unsigned RXL = RXA + 1;

    localparam logic [2:0] A_TXDATA = 3'd0;
    localparam logic [2:0] A_RXDATA = 3'd1;
    localparam logic [2:0] A_STATUS = 3'd2;
    localparam logic [2:0] A_CTRL   = 3'd3;
    localparam logic [2:0] A_IRQ    = 3'd4;
    localparam logic [2:0] A_THR    = 3'd5;

    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    rd_state_t             rd_state_q, rd_state_d;
    logic [DATA_WIDTH-1:0] tx_mem_q [TX_DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem_q [RX_DEPTH];
    logic [TXA-1:0]        tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [RXA-1:0]        rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [TXL-1:0]        tx_level_q, tx_level_d;
    logic [RXL-1:0]        rx_level_q, rx_level_d;
    logic [15:0]           prescale_q, prescale_d;
    logic [4:0]            irq_en_q, irq_en_d;
    logic [7:0]            tx_thr_q, tx_thr_d, rx_thr_q, rx_thr_d;
    logic [2:0]            sticky_q, sticky_d;      // {TX_OVF, RX_FRM, RX_OVR}
    logic                  irq_q, irq_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            resp_q, resp_d;
    logic                  rd_pop_q, rd_pop_d;

    logic                  addr_ok;
    logic [2:0]            reg_idx;
    logic                  wr_ctrl, wr_irq, wr_thr;
    logic                  tx_full, tx_push_req, tx_push, tx_pop, tx_ovf_set;
    logic                  rx_full, rx_push, rx_pop;
    logic [7:0]            tx_level8, rx_level8;
    logic [4:0]            irq_stat;
    logic [31:0]           rdata_c;
    logic [1:0]            resp_c;
    logic                  unused_ok;

    // Address decode: only the six word slots in the low 32 bytes exist.
    assign reg_idx     = ctrl.address[4:2];
    assign addr_ok     = (ctrl.address[7:5] == 3'd0) && (reg_idx <= A_THR);
    assign wr_ctrl     = ctrl.write && addr_ok && (reg_idx == A_CTRL);
    assign wr_irq      = ctrl.write && addr_ok && (reg_idx == A_IRQ);
    assign wr_thr      = ctrl.write && addr_ok && (reg_idx == A_THR);
    assign unused_ok   = ^{ctrl.address[1:0], ctrl.writedata[31:21], ctrl.byteenable[3]};

    // TX FIFO control: a pop in the same cycle frees the slot for a bus push even when full.
    assign tx_full     = (tx_level_q == TXL'(TX_DEPTH));
    assign tx_tvalid   = (tx_level_q != '0);
    assign tx_tdata    = tx_mem_q[tx_rd_ptr_q];
    assign tx_pop      = tx_tvalid && tx_tready;
    assign tx_push_req = ctrl.write && addr_ok && (reg_idx == A_TXDATA) && ctrl.byteenable[0];
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign tx_ovf_set  = tx_push_req && tx_full && !tx_pop;

    // RX FIFO control: the core is refused when full and reports its own overrun.
    assign rx_full     = (rx_level_q == RXL'(RX_DEPTH));
    assign rx_tready   = !rx_full;
    assign rx_push     = rx_tvalid && rx_tready;

    assign tx_level8   = 8'(tx_level_q);
    assign rx_level8   = 8'(rx_level_q);
    assign irq_stat    = {sticky_q,
                          (rx_level8 != 8'd0) && (rx_level8 >= rx_thr_q),
                          (tx_level8 <= tx_thr_q)};

    assign ctrl.readdata    = rdata_q;
    assign ctrl.response    = resp_q;
    assign ctrl.waitrequest = ctrl.read && (rd_state_q == RD_IDLE);
    assign prescale         = prescale_q;
    assign irq              = irq_q;

    // Read mux: value the bus would see if the read were captured this cycle.
    always_comb begin
        rdata_c = '0;
        resp_c  = 2'b00;
        if (!addr_ok) begin
            resp_c = 2'b10;
        end else begin
            case (reg_idx)
                A_RXDATA: begin
                    if (rx_level_q != '0) begin
                        rdata_c[DATA_WIDTH-1:0] = rx_mem_q[rx_rd_ptr_q];
                        rdata_c[31]             = 1'b1;
                    end
                end
                A_STATUS: rdata_c = {14'd0, rx_busy, tx_busy, rx_level8, tx_level8};
                A_CTRL:   rdata_c = {11'd0, irq_en_q, prescale_q};
                A_IRQ:    rdata_c = {27'd0, irq_stat};
                A_THR:    rdata_c = {16'd0, rx_thr_q, tx_thr_q};
                default:  rdata_c = '0;
            endcase
        end
    end

    // Read handshake: capture data in the stall cycle, apply the RX pop in the completing cycle.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        resp_d     = resp_q;
        rd_pop_d   = rd_pop_q;
        rx_pop     = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (ctrl.read) begin
                    rd_state_d = RD_DATA;
                    rdata_d    = rdata_c;
                    resp_d     = resp_c;
                    rd_pop_d   = addr_ok && (reg_idx == A_RXDATA) && (rx_level_q != '0);
                end
            end
            RD_DATA: begin
                rd_state_d = RD_IDLE;
                rx_pop     = ctrl.read && rd_pop_q;
                rd_pop_d   = 1'b0;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Next-state for FIFO pointers/levels, CSRs, sticky flags and the interrupt.
    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q + TXA'(tx_push);
        tx_rd_ptr_d = tx_rd_ptr_q + TXA'(tx_pop);
        tx_level_d  = tx_level_q + TXL'(tx_push) - TXL'(tx_pop);
        rx_wr_ptr_d = rx_wr_ptr_q + RXA'(rx_push);
        rx_rd_ptr_d = rx_rd_ptr_q + RXA'(rx_pop);
        rx_level_d  = rx_level_q + RXL'(rx_push) - RXL'(rx_pop);
        prescale_d  = prescale_q;
        irq_en_d    = irq_en_q;
        tx_thr_d    = tx_thr_q;
        rx_thr_d    = rx_thr_q;
        sticky_d    = sticky_q;
        if (wr_ctrl) begin
            if (ctrl.byteenable[0]) prescale_d[7:0]  = ctrl.writedata[7:0];
            if (ctrl.byteenable[1]) prescale_d[15:8] = ctrl.writedata[15:8];
            if (ctrl.byteenable[2]) irq_en_d         = ctrl.writedata[20:16];
        end
        if (wr_thr) begin
            if (ctrl.byteenable[0]) tx_thr_d = ctrl.writedata[7:0];
            if (ctrl.byteenable[1]) rx_thr_d = ctrl.writedata[15:8];
        end
        if (wr_irq && ctrl.byteenable[0]) begin
            sticky_d = sticky_q & ~ctrl.writedata[4:2];
        end
        // A new event in the same cycle as a clear must survive.
        sticky_d = sticky_d | {tx_ovf_set, rx_frame_error, rx_overrun_error};
        irq_d    = |(irq_stat & irq_en_q);
    end

    // Control and status state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q  <= RD_IDLE;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_level_q  <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_level_q  <= '0;
            prescale_q  <= PRESCALE_RST;
            irq_en_q    <= '0;
            tx_thr_q    <= '0;
            rx_thr_q    <= '0;
            sticky_q    <= '0;
            irq_q       <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= 2'b00;
            rd_pop_q    <= 1'b0;
        end else begin
            rd_state_q  <= rd_state_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_level_q  <= tx_level_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_level_q  <= rx_level_d;
            prescale_q  <= prescale_d;
            irq_en_q    <= irq_en_d;
            tx_thr_q    <= tx_thr_d;
            rx_thr_q    <= rx_thr_d;
            sticky_q    <= sticky_d;
            irq_q       <= irq_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            rd_pop_q    <= rd_pop_d;
        end
    end

    // Character storage; contents are don't-care until a level counter covers them.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wr_ptr_q] <= ctrl.writedata[DATA_WIDTH-1:0];
        if (rx_push) rx_mem_q[rx_wr_ptr_q] <= rx_tdata;
    end
endmodule

// File: tb/tb_uart_fifo_regs.sv
`timescale 1ns/1ps
module tb_uart_fifo_regs;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_tdata, rx_tdata;
    logic       tx_tvalid, tx_tready, rx_tvalid, rx_tready;
    logic       tx_busy, rx_busy, rx_overrun_error, rx_frame_error;
    logic [15:0] prescale;
    logic       irq;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit         tx_ovf_m;

    uart_fifo_regs_if bus();

    uart_fifo_regs #(
        .DATA_WIDTH(8), .TX_DEPTH(16), .RX_DEPTH(16), .PRESCALE_RST(16'd54)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ctrl(bus),
        .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
        .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
        .tx_busy(tx_busy), .rx_busy(rx_busy),
        .rx_overrun_error(rx_overrun_error), .rx_frame_error(rx_frame_error),
        .prescale(prescale), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // All tasks start and end 1ns after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.address = a; bus.writedata = d; bus.byteenable = be; bus.write = 1'b1;
        @(posedge clk); #1;
        bus.write = 1'b0; bus.byteenable = 4'h0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r,
                            output logic w1, output logic w2);
        bus.address = a; bus.read = 1'b1;
        @(negedge clk); w1 = bus.waitrequest;
        @(posedge clk); #1;
        @(negedge clk); w2 = bus.waitrequest; d = bus.readdata; r = bus.response;
        @(posedge clk); #1;
        bus.read = 1'b0;
    endtask

    task automatic core_push(input logic [7:0] d, output logic acc);
        rx_tvalid = 1'b1; rx_tdata = d;
        @(negedge clk); acc = rx_tready;
        @(posedge clk); #1;
        rx_tvalid = 1'b0;
    endtask

    task automatic core_pop(output logic v, output logic [7:0] d);
        tx_tready = 1'b1;
        @(negedge clk); v = tx_tvalid; d = tx_tdata;
        @(posedge clk); #1;
        tx_tready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r; logic w1, w2;
        #22 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (prescale !== 16'd54) begin n_fail++; $display("FAIL reset_prescale got=%0d exp=54", prescale); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq); end
        n_checks++; if (tx_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_tvalid got=%b exp=0", tx_tvalid); end
        n_checks++; if (rx_tready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_tready got=%b exp=1", rx_tready); end
        n_checks++; if (bus.readdata !== 32'h0 || bus.response !== 2'b00 || bus.waitrequest !== 1'b0) begin
            n_fail++; $display("FAIL reset_bus got rd=%h resp=%b wr=%b exp 0/00/0", bus.readdata, bus.response, bus.waitrequest); end
        bus_read(8'h08, d, r, w1, w2);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status got=%h exp=0", d); end
        bus_read(8'h0C, d, r, w1, w2);
        n_checks++; if (d !== 32'h36) begin n_fail++; $display("FAIL reset_ctrl got=%h exp=36", d); end
        bus_read(8'h10, d, r, w1, w2);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL reset_irqstat got=%h exp=1", d); end
        bus_read(8'h14, d, r, w1, w2);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_thr got=%h exp=0", d); end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] d; logic [1:0] r; logic w1, w2; logic v; logic [7:0] c;
        logic [7:0] got[$];
        for (int i = 0; i <= 16; i++) begin
            bus_write(8'h00, 32'(i), 4'h1);
            if (tx_q.size() < 16) tx_q.push_back(8'(i)); else tx_ovf_m = 1'b1;
        end
        bus_read(8'h08, d, r, w1, w2);
        n_checks++; if (d[7:0] !== 8'd16) begin n_fail++; $display("FAIL ovf_level got=%0d exp=16", d[7:0]); end
        bus_read(8'h10, d, r, w1, w2);
        n_checks++; if (d !== 32'h10) begin n_fail++; $display("FAIL ovf_irqstat got=%h exp=10", d); end
        for (int i = 0; i < 20; i++) begin
            core_pop(v, c);
            if (v) got.push_back(c);
        end
        n_checks++; if (got.size() != 16) begin n_fail++; $display("FAIL ovf_drain_count got=%0d exp=16", got.size()); end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            n_checks++; if (got[i] !== tx_q[i]) begin n_fail++; $display("FAIL ovf_drain_data[%0d] got=%h exp=%h", i, got[i], tx_q[i]); end
        end
        tx_q.delete();
        bus_write(8'h10, 32'h10, 4'hF); tx_ovf_m = 1'b0;
        bus_read(8'h10, d, r, w1, w2);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL ovf_clear got=%h exp=1", d); end
    endtask

    task automatic test_rx_irq();
        logic [31:0] d; logic [1:0] r; logic w1, w2; logic acc;
        bus_write(8'h14, 32'h0000_0200, 4'b0011);
        bus_write(8'h0C, 32'h0002_0036, 4'hF);
        core_push(8'hA5, acc);
        core_push(8'h5A, acc);
        @(negedge clk);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rxhi_irq_early got=%b exp=0", irq); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL rxhi_irq got=%b exp=1", irq); end
        @(posedge clk); #1;
        bus_read(8'h04, d, r, w1, w2);
        n_checks++; if (d !== 32'h8000_00A5) begin n_fail++; $display("FAIL rxdata0 got=%h exp=800000a5", d); end
        bus_read(8'h04, d, r, w1, w2);
        n_checks++; if (d !== 32'h8000_005A) begin n_fail++; $display("FAIL rxdata1 got=%h exp=8000005a", d); end
        bus_read(8'h04, d, r, w1, w2);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rxdata_empty got=%h exp=0", d); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rxhi_irq_clear got=%b exp=0", irq); end
    endtask

    task automatic test_rx_full_frame();
        logic [31:0] d; logic [1:0] r; logic w1, w2; logic acc; logic [7:0] c;
        int n_acc = 0;
        bus_write(8'h0C, 32'h0008_0036, 4'hF);
        for (int i = 0; i < 16; i++) begin
            c = 8'($urandom);
            core_push(c, acc);
            if (acc) begin n_acc++; rx_q.push_back(c); end
        end
        n_checks++; if (n_acc != 16) begin n_fail++; $display("FAIL rxfill_accepted got=%0d exp=16", n_acc); end
        core_push(8'hEE, acc);
        n_checks++; if (acc !== 1'b0) begin n_fail++; $display("FAIL rxfull_tready got=%b exp=0", acc); end
        rx_frame_error = 1'b1;
        @(posedge clk); #1;
        rx_frame_error = 1'b0;
        idle(1);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL frm_irq got=%b exp=1", irq); end
        bus_read(8'h10, d, r, w1, w2);
        n_checks++; if (d !== 32'h0B) begin n_fail++; $display("FAIL frm_irqstat got=%h exp=0b", d); end
        bus_write(8'h10, 32'h08, 4'h1);
        bus_read(8'h10, d, r, w1, w2);
        n_checks++; if (d !== 32'h03) begin n_fail++; $display("FAIL frm_cleared got=%h exp=03", d); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL frm_irq_clear got=%b exp=0", irq); end
        while (rx_q.size() != 0) begin
            bus_read(8'h04, d, r, w1, w2);
            n_checks++; if (d !== {1'b1, 23'd0, rx_q[0]}) begin n_fail++; $display("FAIL rxdrain got=%h exp=%h", d, {1'b1, 23'd0, rx_q[0]}); end
            void'(rx_q.pop_front());
        end
        n_checks++; if (rx_tready !== 1'b1) begin n_fail++; $display("FAIL rxdrain_tready got=%b exp=1", rx_tready); end
    endtask

    task automatic test_slverr();
        logic [31:0] d; logic [1:0] r; logic w1, w2;
        bus_read(8'h1C, d, r, w1, w2);
        n_checks++; if (w1 !== 1'b1 || w2 !== 1'b0) begin n_fail++; $display("FAIL slverr_wait got=%b%b exp=10", w1, w2); end
        n_checks++; if (r !== 2'b10 || d !== 32'h0) begin n_fail++; $display("FAIL slverr_resp got=%b/%h exp=10/0", r, d); end
        bus_write(8'h1C, 32'hFFFF_FFFF, 4'hF);
        bus_write(8'hAC, 32'hFFFF_FFFF, 4'hF);
        bus_read(8'h0C, d, r, w1, w2);
        n_checks++; if (d !== 32'h0008_0036 || r !== 2'b00) begin n_fail++; $display("FAIL slverr_ctrl got=%h/%b exp=00080036/00", d, r); end
        bus_read(8'h14, d, r, w1, w2);
        n_checks++; if (d !== 32'h0200) begin n_fail++; $display("FAIL slverr_thr got=%h exp=200", d); end
        bus_read(8'h2C, d, r, w1, w2);
        n_checks++; if (r !== 2'b10 || d !== 32'h0) begin n_fail++; $display("FAIL slverr_hiaddr got=%b/%h exp=10/0", r, d); end
        bus_write(8'h0C, 32'h00AB_1234, 4'b0010);
        bus_read(8'h0C, d, r, w1, w2);
        n_checks++; if (d !== 32'h0008_1236) begin n_fail++; $display("FAIL ctrl_lane got=%h exp=00081236", d); end
    endtask

    task automatic test_tx_full_pushpop();
        logic [31:0] d; logic [1:0] r; logic w1, w2; logic v; logic [7:0] c;
        for (int i = 0; i < 16; i++) begin
            bus_write(8'h00, 32'h40 + 32'(i), 4'h1);
            tx_q.push_back(8'h40 + 8'(i));
        end
        bus.address = 8'h00; bus.writedata = 32'h77; bus.byteenable = 4'h1; bus.write = 1'b1;
        tx_tready = 1'b1;
        @(negedge clk); c = tx_tdata;
        n_checks++; if (c !== tx_q[0]) begin n_fail++; $display("FAIL pp_head got=%h exp=%h", c, tx_q[0]); end
        @(posedge clk); #1;
        bus.write = 1'b0; tx_tready = 1'b0;
        void'(tx_q.pop_front()); tx_q.push_back(8'h77);
        bus_read(8'h08, d, r, w1, w2);
        n_checks++; if (d[7:0] !== 8'd16) begin n_fail++; $display("FAIL pp_level got=%0d exp=16", d[7:0]); end
        bus_read(8'h10, d, r, w1, w2);
        n_checks++; if (d[4] !== 1'b0) begin n_fail++; $display("FAIL pp_no_ovf got=%b exp=0", d[4]); end
        for (int i = 0; i < 16; i++) begin
            core_pop(v, c);
            n_checks++; if (v !== 1'b1 || c !== tx_q[0]) begin n_fail++; $display("FAIL pp_drain[%0d] got=%b/%h exp=1/%h", i, v, c, tx_q[0]); end
            void'(tx_q.pop_front());
        end
    endtask

    task automatic test_random();
        logic [31:0] d, e; logic [1:0] r; logic w1, w2; logic v, acc; logic [7:0] c;
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 5))
                0, 1: begin
                    c = 8'($urandom);
                    bus_write(8'h00, {24'($urandom), c}, 4'h1);
                    if (tx_q.size() < 16) tx_q.push_back(c); else tx_ovf_m = 1'b1;
                end
                2: begin
                    e = (rx_q.size() != 0) ? {1'b1, 23'd0, rx_q[0]} : 32'h0;
                    bus_read(8'h04, d, r, w1, w2);
                    if (rx_q.size() != 0) void'(rx_q.pop_front());
                    n_checks++; if (d !== e) begin n_fail++; $display("FAIL rnd_rxdata it=%0d got=%h exp=%h", it, d, e); end
                end
                3: begin
                    core_pop(v, c);
                    n_checks++; if (v !== (tx_q.size() != 0)) begin n_fail++; $display("FAIL rnd_tvalid it=%0d got=%b exp=%b", it, v, tx_q.size() != 0); end
                    if (v && tx_q.size() != 0) begin
                        n_checks++; if (c !== tx_q[0]) begin n_fail++; $display("FAIL rnd_tdata it=%0d got=%h exp=%h", it, c, tx_q[0]); end
                        void'(tx_q.pop_front());
                    end
                end
                4: begin
                    c = 8'($urandom);
                    core_push(c, acc);
                    n_checks++; if (acc !== (rx_q.size() < 16)) begin n_fail++; $display("FAIL rnd_rx_tready it=%0d got=%b exp=%b", it, acc, rx_q.size() < 16); end
                    if (acc) rx_q.push_back(c);
                end
                default: begin
                    tx_busy = 1'($urandom); rx_busy = 1'($urandom);
                    e = {14'd0, rx_busy, tx_busy, 8'(rx_q.size()), 8'(tx_q.size())};
                    bus_read(8'h08, d, r, w1, w2);
                    n_checks++; if (d !== e) begin n_fail++; $display("FAIL rnd_status it=%0d got=%h exp=%h", it, d, e); end
                end
            endcase
        end
        bus_read(8'h10, d, r, w1, w2);
        n_checks++; if (d[4] !== tx_ovf_m) begin n_fail++; $display("FAIL rnd_txovf got=%b exp=%b", d[4], tx_ovf_m); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d; logic [1:0] r; logic w1, w2; logic acc;
        bus_write(8'h0C, 32'h0000_1234, 4'b0011);
        for (int i = 0; i < 5; i++) bus_write(8'h00, 32'(i), 4'h1);
        for (int i = 0; i < 16; i++) core_push(8'(i), acc);
        tx_tready = 1'b1;
        @(negedge clk);
        n_checks++; if (tx_tvalid !== 1'b1 || rx_tready !== 1'b0) begin n_fail++; $display("FAIL arst_pre got=%b/%b exp=1/0", tx_tvalid, rx_tready); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (tx_tvalid !== 1'b0) begin n_fail++; $display("FAIL arst_tx_tvalid got=%b exp=0", tx_tvalid); end
        n_checks++; if (rx_tready !== 1'b1) begin n_fail++; $display("FAIL arst_rx_tready got=%b exp=1", rx_tready); end
        n_checks++; if (prescale !== 16'd54 || irq !== 1'b0) begin n_fail++; $display("FAIL arst_regs got=%0d/%b exp=54/0", prescale, irq); end
        tx_tready = 1'b0; tx_busy = 1'b0; rx_busy = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tx_q.delete(); rx_q.delete(); tx_ovf_m = 1'b0;
        bus_read(8'h08, d, r, w1, w2);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL arst_status got=%h exp=0", d); end
    endtask

    initial begin
        bus.address = 8'h0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = 32'h0; bus.byteenable = 4'h0;
        tx_tready = 1'b0; rx_tvalid = 1'b0; rx_tdata = 8'h0;
        tx_busy = 1'b0; rx_busy = 1'b0; rx_overrun_error = 1'b0; rx_frame_error = 1'b0;
        tx_ovf_m = 1'b0;
        test_reset();
        test_tx_overflow();
        test_rx_irq();
        test_rx_full_frame();
        test_slverr();
        test_tx_full_pushpop();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
